// File: rtl/console_vtg.sv
// Console video timing generator: raster counters, pixel request port, latency-matched sync/DE pipeline.
// Optional 50% scanline dimming on odd rows when CONSOLE_VTG_SCANLINE_EN is defined.
module console_vtg #(
  parameter int COLOR_IN  = 3,
  parameter int COLOR_OUT = 8,
  parameter int COORD_W   = 12,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 hs_pol,
  input  logic                 vs_pol,
  output logic [COORD_W-1:0]   req_col,
  output logic [COORD_W-1:0]   req_row,
  output logic                 req_valid,
  input  logic [COLOR_IN-1:0]  pix_r,
  input  logic [COLOR_IN-1:0]  pix_g,
  input  logic [COLOR_IN-1:0]  pix_b,
  output logic [COLOR_OUT-1:0] vga_r,
  output logic [COLOR_OUT-1:0] vga_g,
  output logic [COLOR_OUT-1:0] vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SS   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SE   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_SS   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SE   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [COLOR_OUT-1:0] expand(input logic [COLOR_IN-1:0] c);
    logic [COLOR_OUT-1:0] o;
    o = '0;
    for (int i = 0; i < COLOR_OUT; i++) o[COLOR_OUT-1-i] = c[COLOR_IN-1-(i % COLOR_IN)];
    return o;
  endfunction

  logic [COORD_W-1:0] r_h, r_v;
  logic [PIX_LAT-1:0] r_sr_de, r_sr_hs, r_sr_vs, r_sr_fs;
  logic               r_hs_pol, r_vs_pol, r_hs_pol_out, r_vs_pol_out;

  logic w_active, w_hs_raw, w_vs_raw, w_origin;
  logic w_tail_de, w_tail_hs, w_tail_vs, w_tail_fs, w_hs_pol_now, w_vs_pol_now;
  logic [COLOR_OUT-1:0] w_r_px, w_g_px, w_b_px;

  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_raw = (r_h >= H_SS) && (r_h < H_SE);
  assign w_vs_raw = (r_v >= V_SS) && (r_v < V_SE);
  assign w_origin = (r_h == '0) && (r_v == '0);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

`ifdef CONSOLE_VTG_SCANLINE_EN
  logic [PIX_LAT-1:0] r_sr_odd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sr_odd <= '0;
    else if (ce) begin
      r_sr_odd[0] <= r_v[0];
      for (int i = 1; i < PIX_LAT; i++) r_sr_odd[i] <= r_sr_odd[i-1];
    end
  end
  assign w_r_px = r_sr_odd[PIX_LAT-1] ? (expand(pix_r) >> 1) : expand(pix_r);
  assign w_g_px = r_sr_odd[PIX_LAT-1] ? (expand(pix_g) >> 1) : expand(pix_g);
  assign w_b_px = r_sr_odd[PIX_LAT-1] ? (expand(pix_b) >> 1) : expand(pix_b);
`else
  assign w_r_px = expand(pix_r);
  assign w_g_px = expand(pix_g);
  assign w_b_px = expand(pix_b);
`endif

  // Stage 0 of the delay line is loaded alongside the request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_col   <= '0;
      req_row   <= '0;
      req_valid <= 1'b0;
      r_sr_de   <= '0;
      r_sr_hs   <= '0;
      r_sr_vs   <= '0;
      r_sr_fs   <= '0;
      r_hs_pol  <= 1'b0;
      r_vs_pol  <= 1'b0;
    end else if (ce) begin
      req_col    <= r_h;
      req_row    <= r_v;
      req_valid  <= w_active;
      r_sr_de[0] <= w_active;
      r_sr_hs[0] <= w_hs_raw;
      r_sr_vs[0] <= w_vs_raw;
      r_sr_fs[0] <= w_origin;
      for (int i = 1; i < PIX_LAT; i++) begin
        r_sr_de[i] <= r_sr_de[i-1];
        r_sr_hs[i] <= r_sr_hs[i-1];
        r_sr_vs[i] <= r_sr_vs[i-1];
        r_sr_fs[i] <= r_sr_fs[i-1];
      end
      if (w_origin) begin
        r_hs_pol <= hs_pol;
        r_vs_pol <= vs_pol;
      end
    end
  end

  assign w_tail_de = r_sr_de[PIX_LAT-1];
  assign w_tail_hs = r_sr_hs[PIX_LAT-1];
  assign w_tail_vs = r_sr_vs[PIX_LAT-1];
  assign w_tail_fs = r_sr_fs[PIX_LAT-1];

  // The output-side polarity only switches when pixel (0,0) leaves, so the
  // previous frame's tail keeps its own polarity.
  assign w_hs_pol_now = w_tail_fs ? r_hs_pol : r_hs_pol_out;
  assign w_vs_pol_now = w_tail_fs ? r_vs_pol : r_vs_pol_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
      vga_de       <= 1'b0;
      vga_hs       <= 1'b1;
      vga_vs       <= 1'b1;
      frame_start  <= 1'b0;
      r_hs_pol_out <= 1'b0;
      r_vs_pol_out <= 1'b0;
    end else if (ce) begin
      vga_r        <= w_tail_de ? w_r_px : '0;
      vga_g        <= w_tail_de ? w_g_px : '0;
      vga_b        <= w_tail_de ? w_b_px : '0;
      vga_de       <= w_tail_de;
      vga_hs       <= w_tail_hs ~^ w_hs_pol_now;
      vga_vs       <= w_tail_vs ~^ w_vs_pol_now;
      frame_start  <= w_tail_fs;
      r_hs_pol_out <= w_hs_pol_now;
      r_vs_pol_out <= w_vs_pol_now;
    end
  end

endmodule

// File: doc/console_vtg.md
CONSOLE_VTG -- requirements
Module: console_vtg

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- COLOR_IN, 3, input bits per colour channel.
- COLOR_OUT, 8, output bits per channel; must be at least COLOR_IN.
- COORD_W, 12, counter and coordinate width.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480/10/2/33, vertical timing in lines.
- PIX_LAT, 2, pixel-source latency in ce ticks, range 1..8.

REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- ce, in, 1, pixel clock enable.
- hs_pol, in, 1, 1 = active-high hsync.
- vs_pol, in, 1, 1 = active-high vsync.
- req_col, out, COORD_W, requested column.
- req_row, out, COORD_W, requested row.
- req_valid, out, 1, request is inside the active area.
- pix_r / pix_g / pix_b, in, COLOR_IN each, returned pixel.
- vga_r / vga_g / vga_b, out, COLOR_OUT each, expanded colour.
- vga_hs, out, 1, horizontal sync.
- vga_vs, out, 1, vertical sync.
- vga_de, out, 1, display enable.
- frame_start, out, 1, one-ce-tick pulse.

Function
REQ-003 All state SHALL advance only on clk edges where ce=1; with ce=0 every register SHALL hold.
REQ-004 The horizontal counter SHALL run 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
REQ-005 The horizontal counter SHALL wrap to 0 after H_TOTAL-1, and each wrap SHALL advance the vertical counter.
REQ-006 The vertical counter SHALL wrap to 0 after V_TOTAL-1.
REQ-007 On each ce tick, req_col/req_row SHALL be registered from the counters.
REQ-008 req_valid SHALL be registered as h<H_ACTIVE and v<V_ACTIVE.
REQ-009 Raw hsync SHALL be true for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-010 Raw vsync SHALL be true for the lines in the same window computed with the V parameters.
REQ-011 Raw hsync, raw vsync, req_valid and frame-start SHALL pass through a PIX_LAT-deep shift register clocked by ce.
REQ-012 Outputs SHALL be registered from the shift register tail and pix_* sampled on the same ce tick.
REQ-013 Total latency from the request to the matching vga_* output SHALL be PIX_LAT ce ticks.
REQ-014 vga_de SHALL equal the delayed req_valid.
REQ-015 When vga_de=0, vga_r/g/b SHALL be forced to 0.
REQ-016 Colour expansion SHALL replicate the input channel MSB-first until COLOR_OUT bits are filled (3->8: c2 c1 c0 c2 c1 c0 c2 c1).
REQ-017 vga_hs SHALL equal delayed raw hsync XNOR the latched hs polarity; vga_vs SHALL be formed the same way from vs polarity.
REQ-018 hs_pol/vs_pol SHALL be latched only on the ce tick where h=0 and v=0; a change mid-frame SHALL take effect at the next frame.
REQ-019 frame_start SHALL pulse for exactly one ce tick, aligned with the output of pixel (0,0).
REQ-020 ce held low across a counter wrap SHALL NOT skip or duplicate any count.

Reset
REQ-021 While rst=1, the counters, pipeline, vga_r/g/b, vga_de, req_valid, req_col, req_row and frame_start SHALL be 0.
REQ-022 While rst=1, the latched polarities SHALL be 0, so vga_hs=vga_vs=1 (inactive).
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately.
REQ-024 The first ce tick after reset release SHALL issue the request for (0,0) with req_valid=1.

Configuration
REQ-025 With CONSOLE_VTG_SCANLINE_EN defined, every output pixel on an odd row with vga_de=1 SHALL be the expanded value shifted right by 1 (50% dim).
REQ-026 The odd-row indication for REQ-025 SHALL be carried through the pipeline.
REQ-027 Without CONSOLE_VTG_SCANLINE_EN, all rows SHALL be undimmed and no extra pipeline bit SHALL exist.

Verification
REQ-028 Reset release with ce=1 and defaults: one frame SHALL be exactly 800x525 ce ticks, and frame_start SHALL repeat every 420000 ticks.
REQ-029 hs_pol=0: vga_hs SHALL be low for 96 ticks, starting 656+PIX_LAT ticks after the (0,0) request.
REQ-030 vs_pol=0: vga_vs SHALL be low for lines 490-491.
REQ-031 pix_r=3'b101 at (5,0): vga_r SHALL be 8'hB6 with vga_de=1, 2 ticks after req_col=5.
REQ-032 During blanking with pix_*=7: vga_r/g/b SHALL be 0.
REQ-033 Toggle hs_pol at line 100: vga_hs polarity SHALL be unchanged until the next frame_start.
REQ-034 ce toggling 1-of-4 with rst pulsed at line 300: counters SHALL be 0, vga_hs=vga_vs=1, and a clean restart SHALL follow.
REQ-035 With the macro defined, pix_g=7 on row 1: vga_g SHALL be 8'h7F.
